// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction fetch controller.
//   - fetch_state_e : controller state encoding
//   - BRC_PREFIX    : inst[8:3] opcode of the conditional branch
//   - JMP_PREFIX    : inst[8:6] opcode of the unconditional jump
//   - HALT_INST_DEF : default program-terminating encoding
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  localparam logic [5:0] BRC_PREFIX    = 6'b010101;
  localparam logic [2:0] JMP_PREFIX    = 3'b111;
  localparam logic [8:0] HALT_INST_DEF = 9'b011111_111;

  function automatic logic is_brc(input logic [8:0] i);
    return i[8:3] == BRC_PREFIX;
  endfunction

  function automatic logic is_jmp(input logic [8:0] i);
    return i[8:6] == JMP_PREFIX;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational control-flow decode and target computation.
//   issue_pc in  8  address of the instruction on inst
//   inst     in  9  instruction word being issued
//   target   out 8  branch/jump destination (mod 256)
//   is_ctrl  out 1  inst is a BRC or JMP (BRC taken-ness is decided by the caller)
import fetch_ctrl_pkg::*;

module fetch_next_pc (
  input  logic [7:0] issue_pc,
  input  logic [8:0] inst,
  output logic [7:0] target,
  output logic       is_ctrl
);

  always_comb begin
    // BRC: relative forward offset, 8-bit add wraps naturally
    target  = issue_pc + 8'd1 + {5'd0, inst[2:0]};
    is_ctrl = is_brc(inst);
    // JMP: absolute word-aligned target; opcodes are disjoint from BRC
    if (is_jmp(inst)) begin
      target  = {inst[5:0], 2'b00};
      is_ctrl = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for a registered-output instruction
// memory (inst = mem[pc] one cycle later).
//   clk         in  1  rising-edge clock
//   rst_n       in  1  asynchronous active-low reset
//   start       in  1  pulse: begin execution at start_addr (IDLE/DONE only)
//   start_addr  in  8  first fetch address
//   stall       in  1  hold current instruction (no retire, no advance)
//   branch_flag in  1  registered EQ flag from datapath, qualifies BRC
//   inst        in  9  instruction memory read data
//   pc          out 8  instruction memory address (combinational)
//   issue       out 1  inst is valid and executed this cycle
//   issue_pc    out 8  address of the word currently on inst
//   busy        out 1  FILL or RUN
//   done        out 1  DONE
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter logic [8:0] HALT_INST = HALT_INST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic       stall,
  input  logic       branch_flag,
  input  logic [8:0] inst,
  output logic [7:0] pc,
  output logic       issue,
  output logic [7:0] issue_pc,
  output logic       busy,
  output logic       done
);

  fetch_state_e st, st_n;
  logic [7:0]   fetch_pc, fetch_pc_n, issue_pc_n;
  logic         v, v_n;
  logic [7:0]   target;
  logic         is_ctrl, taken, is_halt;

  fetch_next_pc u_npc (
    .issue_pc (issue_pc),
    .inst     (inst),
    .target   (target),
    .is_ctrl  (is_ctrl)
  );

  // A control op that is not a JMP is a BRC, which needs the flag.
  assign taken   = is_ctrl & (is_jmp(inst) | branch_flag);
  assign is_halt = (inst == HALT_INST);

  // Under stall re-present issue_pc so memory re-reads the held word.
  assign pc    = (st == ST_RUN && stall) ? issue_pc : fetch_pc;
  assign issue = (st == ST_RUN) & v & ~stall;
  assign busy  = (st == ST_FILL) | (st == ST_RUN);
  assign done  = (st == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      fetch_pc <= 8'd0;
      issue_pc <= 8'd0;
      v        <= 1'b0;
    end else begin
      st       <= st_n;
      fetch_pc <= fetch_pc_n;
      issue_pc <= issue_pc_n;
      v        <= v_n;
    end
  end

  always_comb begin
    st_n       = st;
    fetch_pc_n = fetch_pc;
    issue_pc_n = issue_pc;
    v_n        = v;
    case (st)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          fetch_pc_n = start_addr;
          st_n       = ST_FILL;
        end
      end
      ST_FILL: begin
        issue_pc_n = fetch_pc;
        fetch_pc_n = fetch_pc + 8'd1;
        v_n        = 1'b1;
        st_n       = ST_RUN;
      end
      ST_RUN: begin
        // stall freezes everything; control flow is only judged on issue
        if (!stall) begin
          if (v && is_halt) begin
            st_n = ST_DONE;
            v_n  = 1'b0;
          end else if (v && taken) begin
            // word already fetched from issue_pc+1 becomes the bubble
            fetch_pc_n = target;
            v_n        = 1'b0;
          end else begin
            issue_pc_n = fetch_pc;
            fetch_pc_n = fetch_pc + 8'd1;
            v_n        = 1'b1;
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter HALT_INST, default 9'b011111_111, is the instruction encoding that ends a program.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle pulse that begins execution at start_addr.
REQ-006 start_addr  in  8  first fetch address.
REQ-007 stall  in  1  datapath hold request; current instruction is neither retired nor advanced.
REQ-008 branch_flag  in  1  registered EQ result from the datapath.
REQ-009 inst  in  9  instruction memory data; it registers mem[pc] on each rising edge.
REQ-010 pc  out  8  instruction memory address, combinational.
REQ-011 issue  out  1  inst is valid and is executed by the datapath this cycle.
REQ-012 issue_pc  out  8  address of the instruction currently on inst.
REQ-013 busy  out  1  high in FILL and RUN.
REQ-014 done  out  1  high in DONE.

Function
REQ-015 States are IDLE, FILL, RUN and DONE, held in an internal fetch_pc, issue_pc and valid bit v.
REQ-016 IDLE/DONE + start: fetch_pc<=start_addr, done<=0, state->FILL; start is ignored in FILL/RUN.
REQ-017 FILL (one cycle): issue_pc<=fetch_pc, fetch_pc<=fetch_pc+1, v<=1, state->RUN; first issue occurs 2 cycles after the start edge.
REQ-018 pc = issue_pc when state==RUN and stall=1; otherwise pc = fetch_pc.
REQ-019 issue = (state==RUN) & v & !stall.
REQ-020 RUN with stall=1 holds all registers; inst therefore re-reads the same word each cycle.
REQ-021 RUN, !stall, v=0 (squash slot): issue_pc<=fetch_pc, fetch_pc<=fetch_pc+1, v<=1.
REQ-022 RUN, issue, no control flow: issue_pc<=fetch_pc, fetch_pc<=fetch_pc+1, v<=1.
REQ-023 BRC is inst[8:3]==6'b010101; it is taken when branch_flag=1 is sampled in its issue cycle, target = issue_pc+1+inst[2:0].
REQ-024 JMP is inst[8:6]==3'b111; it is always taken, target = {inst[5:0],2'b00}.
REQ-025 On a taken BRC/JMP issue: fetch_pc<=target, v<=0, which squashes the already-fetched word; penalty is exactly one bubble.
REQ-026 A not-taken BRC behaves per REQ-022.
REQ-027 On issue of HALT_INST: state->DONE, v<=0; the HALT itself has issue=1 for that cycle.
REQ-028 All pc arithmetic is mod 256; 255+1 and branch targets wrap to 0.
REQ-029 Stall takes priority over HALT/branch evaluation; both are evaluated only in the issue cycle.

Reset
REQ-030 rst_n low forces, asynchronously: state=IDLE, fetch_pc=0, issue_pc=0, v=0, issue=0, busy=0, done=0.
REQ-031 Reset mid-RUN abandons the program; no issue occurs until a new start after rst_n rises.

Structure
REQ-032 A shared package holds the state enum, the BRC prefix 6'b010101, the JMP prefix 3'b111 and the default HALT encoding.
REQ-033 Target computation is a combinational sub-module, fetch_next_pc, with inputs issue_pc and inst and outputs target and is_ctrl; the FSM remains in fetch_ctrl.

Verification
REQ-034 start, start_addr=0, straight-line code -> issue first at cycle 2, issue_pc=0,1,2,... once per cycle.
REQ-035 BRC off=1 at 16, branch_flag=1 -> one bubble, next issue_pc=18; with branch_flag=0 -> next issue_pc=17, no bubble.
REQ-036 JMP imm=10 at 19 -> one bubble, next issue_pc=40.
REQ-037 stall high 3 cycles while issue_pc=5 -> pc=5, issue=0 throughout; on release issue_pc=5, then 6.
REQ-038 HALT_INST at 20 -> issue for 20, then done=1, busy=0; a new start restarts and clears done; straight-line run from 254 -> issue_pc 254,255,0.
REQ-039 rst_n low during RUN -> all outputs at reset values immediately; no issue until the next start.
